// File: rtl/traffic_req_scheduler.sv
// Side-road request scheduler: latches requests, enforces a minimum main-road green
// hold, pulses the traffic light's req input and tracks which requester is served.
module traffic_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int MIN_GAP = 60,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic             green_main,
    input  logic             green_side,
    output logic             light_req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] pending,
    output logic             busy,
    output logic             timeout_err
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_SIDE = 3'd2,
        ST_SERVE     = 3'd3,
        ST_RECOVER   = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic [TO_W-1:0]    to_r, to_s;
    logic [PTR_W-1:0]   ptr_r, ptr_s;
    logic [PTR_W-1:0]   win_r, win_s;
    logic [N_REQ-1:0]   pending_r, pending_s;
    logic [N_REQ-1:0]   clr_s;
    logic               err_r, err_s;
    logic               light_req_r;
    logic [N_REQ-1:0]   grant_r;
    logic               busy_r;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // First set bit at or after the pointer, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] p,
                                                 input logic [PTR_W-1:0] ptr);
        logic             found;
        logic [PTR_W-1:0] w;
        int               idx;
        found = 1'b0;
        w     = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && p[idx]) begin
                found = 1'b1;
                w     = PTR_W'(idx);
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Next-state, counters, pointer and pending-mask computation.
    always_comb begin
        state_s = state_r;
        gap_s   = gap_r;
        to_s    = to_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        err_s   = err_r;
        clr_s   = {N_REQ{1'b0}};

        if (!green_main) begin
            gap_s = {GAP_W{1'b0}};
        end else if (state_r == ST_IDLE && gap_r != GAP_W'(MIN_GAP)) begin
            gap_s = gap_r + GAP_W'(1);
        end else begin
            gap_s = gap_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (pending_r != {N_REQ{1'b0}} && gap_r == GAP_W'(MIN_GAP) && green_main) begin
                    state_s = ST_ISSUE;
                    win_s   = rr_pick(pending_r, ptr_r);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT_SIDE;
                to_s    = {TO_W{1'b0}};
            end
            ST_WAIT_SIDE: begin
                if (green_side) begin
                    state_s = ST_SERVE;
                end else if (to_r == TO_W'(TIMEOUT - 1)) begin
                    // Light never answered: give up, keep requests for the next round.
                    to_s    = TO_W'(TIMEOUT);
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                    gap_s   = {GAP_W{1'b0}};
                end else begin
                    to_s = to_r + TO_W'(1);
                end
            end
            ST_SERVE: begin
                if (!green_side) begin
                    clr_s   = onehot(win_r);
                    state_s = ST_RECOVER;
                    if (win_r == PTR_W'(N_REQ - 1)) begin
                        ptr_s = {PTR_W{1'b0}};
                    end else begin
                        ptr_s = win_r + PTR_W'(1);
                    end
                end else begin
                    state_s = ST_SERVE;
                end
            end
            ST_RECOVER: begin
                if (green_main) begin
                    state_s = ST_IDLE;
                    gap_s   = {GAP_W{1'b0}};
                end else begin
                    state_s = ST_RECOVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gap_s   = {GAP_W{1'b0}};
            end
        endcase

        pending_s = (pending_r & ~clr_s) | req_in;
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gap_r       <= {GAP_W{1'b0}};
            to_r        <= {TO_W{1'b0}};
            ptr_r       <= {PTR_W{1'b0}};
            win_r       <= {PTR_W{1'b0}};
            pending_r   <= {N_REQ{1'b0}};
            err_r       <= 1'b0;
            light_req_r <= 1'b0;
            grant_r     <= {N_REQ{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            gap_r       <= gap_s;
            to_r        <= to_s;
            ptr_r       <= ptr_s;
            win_r       <= win_s;
            pending_r   <= pending_s;
            err_r       <= err_s;
            light_req_r <= (state_s == ST_ISSUE);
            grant_r     <= (state_s == ST_SERVE) ? onehot(win_s) : {N_REQ{1'b0}};
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign light_req   = light_req_r;
    assign grant       = grant_r;
    assign pending     = pending_r;
    assign busy        = busy_r;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_traffic_req_scheduler.sv
// Directed bench for traffic_req_scheduler; cycle c is the period after the c-th
// clock edge following reset release, inputs set in cycle c are sampled at its end.
module tb_traffic_req_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic       green_main;
    logic       green_side;
    logic       light_req;
    logic [3:0] grant;
    logic [3:0] pending;
    logic       busy;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lr_cnt = 0;
    int base;

    traffic_req_scheduler #(.N_REQ(4), .MIN_GAP(60), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .green_main(green_main),
        .green_side(green_side), .light_req(light_req), .grant(grant),
        .pending(pending), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Pulses seen in cycles strictly before the current sampling point.
    always @(negedge clk) begin
        if (light_req === 1'b1) lr_cnt <= lr_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_in = 4'b0000; green_main = 1'b0; green_side = 1'b0;
        step(); step(); step();
        rst = 1'b0; green_main = 1'b1; cyc = 0;
        chk("rst_light_req", 32'(light_req), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(timeout_err), 32'h0);
        base = lr_cnt;

        // 1: single request, normal timing
        run_to(10); req_in = 4'b0001;
        step(); req_in = 4'b0000;
        chk("t1_pending_set", 32'(pending), 32'h1);
        run_to(60);
        chk("t1_no_early_req", 32'(light_req), 32'h0);
        run_to(61);
        chk("t1_light_req", 32'(light_req), 32'h1);
        chk("t1_no_pulse_before", 32'(lr_cnt - base), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        step(); green_main = 1'b0;
        chk("t1_pulse_once", 32'(light_req), 32'h0);
        run_to(67); green_side = 1'b1;
        run_to(68);
        chk("t1_grant", 32'(grant), 32'h1);
        run_to(97); green_side = 1'b0;
        chk("t1_grant_end", 32'(grant), 32'h1);
        step();
        chk("t1_grant_off", 32'(grant), 32'h0);
        chk("t1_pending_clr", 32'(pending), 32'h0);
        chk("t1_busy_recover", 32'(busy), 32'h1);
        run_to(100); green_main = 1'b1;
        step();
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_single_pulse", 32'(lr_cnt - base), 32'h1);

        // 2: round robin, pointer now at 1
        run_to(102); req_in = 4'b1010;
        step(); req_in = 4'b0000;
        chk("t2_pending", 32'(pending), 32'ha);
        run_to(161);
        chk("t2_gap_a", 32'(light_req), 32'h0);
        step();
        chk("t2_req_a", 32'(light_req), 32'h1);
        step(); green_main = 1'b0;
        run_to(165); green_side = 1'b1;
        step();
        chk("t2_grant_a", 32'(grant), 32'h2);
        run_to(170); green_side = 1'b0;
        step();
        chk("t2_pending_a", 32'(pending), 32'h8);
        step(); green_main = 1'b1;
        run_to(233);
        chk("t2_gap_b", 32'(light_req), 32'h0);
        step();
        chk("t2_req_b", 32'(light_req), 32'h1);
        step(); green_main = 1'b0;
        green_side = 1'b1;
        step();
        chk("t2_grant_b", 32'(grant), 32'h8);
        run_to(240); green_side = 1'b0;
        step(); green_main = 1'b1;
        chk("t2_pending_b", 32'(pending), 32'h0);
        step(); req_in = 4'b1111;
        step(); req_in = 4'b0000;
        chk("t2_pending_all", 32'(pending), 32'hf);
        run_to(303);
        chk("t2_req_c", 32'(light_req), 32'h1);
        step(); green_main = 1'b0; green_side = 1'b1;
        run_to(306);
        chk("t2_grant_wrap", 32'(grant), 32'h1);

        // 5: set and clear of pending[0] in the same cycle
        run_to(310); green_side = 1'b0; req_in = 4'b0001;
        step(); req_in = 4'b0000; green_main = 1'b1;
        chk("t5_pending_keep", 32'(pending), 32'hf);

        // 6: reset during SERVE (winner is requester 1)
        run_to(373);
        chk("t6_req", 32'(light_req), 32'h1);
        step(); green_main = 1'b0; green_side = 1'b1;
        step();
        chk("t6_grant", 32'(grant), 32'h2);
        run_to(378); rst = 1'b1;
        step(); rst = 1'b0; green_side = 1'b0; green_main = 1'b1;
        chk("t6_grant0", 32'(grant), 32'h0);
        chk("t6_pending0", 32'(pending), 32'h0);
        chk("t6_busy0", 32'(busy), 32'h0);
        chk("t6_light_req0", 32'(light_req), 32'h0);
        base = lr_cnt;
        run_to(479);
        chk("t6_no_req_after", 32'(lr_cnt - base), 32'h0);

        // 3: gap enforcement with a one-cycle green_main drop
        step(); green_main = 1'b0;
        step(); green_main = 1'b1;
        run_to(501); req_in = 4'b0001;
        step(); req_in = 4'b0000;
        run_to(521); green_main = 1'b0;
        step(); green_main = 1'b1;
        base = lr_cnt;
        run_to(542);
        chk("t3_no_req_old_gap", 32'(light_req), 32'h0);
        run_to(583);
        chk("t3_no_early", 32'(lr_cnt - base), 32'h0);
        chk("t3_req", 32'(light_req), 32'h1);

        // 4: timeout with green_side held low
        run_to(598);
        chk("t4_err_before", 32'(timeout_err), 32'h0);
        chk("t4_busy_wait", 32'(busy), 32'h1);
        step();
        chk("t4_err", 32'(timeout_err), 32'h1);
        chk("t4_idle", 32'(busy), 32'h0);
        chk("t4_pending_kept", 32'(pending), 32'h1);
        run_to(659);
        chk("t4_gap", 32'(light_req), 32'h0);
        step();
        chk("t4_req_again", 32'(light_req), 32'h1);
        run_to(700);
        chk("t4_err_sticky", 32'(timeout_err), 32'h1);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("t4_err_cleared", 32'(timeout_err), 32'h0);
        chk("t4_pending_rst", 32'(pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
